// File: rtl/rect_fill_pkg.sv
// Shared video constants and types for the rectangle fill engine.
// Framebuffer geometry, the RGB_444 word type, the fill command and the engine state.
package rect_fill_pkg;

  localparam int BYTE_BITS      = 4;
  localparam int BYTES_PER_WORD = 3;
  localparam int FB_W           = 160;
  localparam int FB_H           = 120;

  localparam int WORD_BITS = BYTE_BITS * BYTES_PER_WORD;
  localparam int ADDR_BITS = $clog2(FB_W * FB_H);
  localparam int X_BITS    = $clog2(FB_W);
  localparam int Y_BITS    = $clog2(FB_H);

  typedef logic [WORD_BITS-1:0] rgb_444_t;

  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [X_BITS:0]   w;
    logic [Y_BITS:0]   h;
    rgb_444_t          color;
  } fill_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Exclusive end coordinate of a span, clipped to the framebuffer edge.
  function automatic int unsigned clip_end(input int unsigned start,
                                           input int unsigned len,
                                           input int unsigned limit);
    return (start + len > limit) ? limit : start + len;
  endfunction

endpackage

// File: rtl/rect_fill.sv
// Bus-master fill engine: writes one colour into a clipped rectangle of the framebuffer.
// Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready; a bus beat completes on ack, or is refused on retry and reissued after one idle cycle.
module rect_fill
  import rect_fill_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [X_BITS-1:0]         cmd_x,
  input  logic [Y_BITS-1:0]         cmd_y,
  input  logic [X_BITS:0]           cmd_w,
  input  logic [Y_BITS:0]           cmd_h,
  input  logic [WORD_BITS-1:0]      cmd_color,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_BITS-1:0]      addr,
  output logic [WORD_BITS-1:0]      out,
  output logic [BYTES_PER_WORD-1:0] select,
  output logic                      write,
  output logic                      strobe,
  input  logic                      ack,
  input  logic                      retry,
  output state_t                    fsm_state
);

  localparam logic [X_BITS:0]      FB_W_X = (X_BITS+1)'(FB_W);
  localparam logic [Y_BITS:0]      FB_H_Y = (Y_BITS+1)'(FB_H);
  localparam logic [ADDR_BITS-1:0] FB_W_A = ADDR_BITS'(FB_W);

  state_t                state, state_nx;
  fill_cmd_t             cmd_q;
  logic [X_BITS:0]       x_end, col;
  logic [Y_BITS:0]       y_end, row;
  logic [ADDR_BITS-1:0]  row_base;
  logic [ADDR_BITS-1:0]  setup_base;
  logic [ADDR_BITS-1:0]  start_x;
  logic                  empty_rect;
  logic                  last_col;
  logic                  last_word;

  assign empty_rect = ({1'b0, cmd_q.x} >= FB_W_X) || ({1'b0, cmd_q.y} >= FB_H_Y) ||
                      (cmd_q.w == '0) || (cmd_q.h == '0);
  assign setup_base = FB_W_A * ADDR_BITS'(cmd_q.y);
  assign start_x    = ADDR_BITS'(cmd_q.x);
  assign last_col   = (col + 1'b1) == x_end;
  assign last_word  = last_col && ((row + 1'b1) == y_end);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (cmd_valid) state_nx = ST_SETUP;
      ST_SETUP:   state_nx = empty_rect ? ST_DONE : ST_WRITE;
      ST_WRITE: begin
        // ack has priority over a simultaneous retry
        if (ack)        state_nx = last_word ? ST_DONE : ST_WRITE;
        else if (retry) state_nx = ST_BACKOFF;
      end
      ST_BACKOFF: state_nx = ST_WRITE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    strobe    = 1'b0;
    case (state)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_WRITE: begin
        busy   = 1'b1;
        strobe = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default:  busy = 1'b1;
    endcase
  end

  assign write     = strobe;
  assign select    = '1;
  assign out       = cmd_q.color;
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q    <= '0;
      x_end    <= '0;
      y_end    <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
        ST_SETUP: begin
          x_end    <= (X_BITS+1)'(clip_end(32'(cmd_q.x), 32'(cmd_q.w), FB_W));
          y_end    <= (Y_BITS+1)'(clip_end(32'(cmd_q.y), 32'(cmd_q.h), FB_H));
          row_base <= setup_base;
          addr     <= setup_base + start_x;
          col      <= {1'b0, cmd_q.x};
          row      <= {1'b0, cmd_q.y};
        end
        ST_WRITE: begin
          if (ack) begin
            if (last_col) begin
              col      <= {1'b0, cmd_q.x};
              row      <= row + 1'b1;
              row_base <= row_base + FB_W_A;
              addr     <= row_base + FB_W_A + start_x;
            end else begin
              col  <= col + 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
